// File: rtl/uart_apb_master.sv
// uart_apb_master: bridges a simple valid/ready host command channel onto an
// APB master port. Only one transfer is outstanding at a time.
// Optional feature: define UART_APB_MASTER_TIMEOUT_EN to abort an ACCESS
// phase that sees no pReady for TIMEOUT_CYCLES cycles. The aborted transfer
// completes with rsp_err=1 and rsp_rdata=0.
module uart_apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        pClk,
  input  logic        pReset,
  // host command channel
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  // host response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // APB request
  output logic        pSel,
  output logic        pEnable,
  output logic        pWrite,
  output logic [31:0] pAddr,
  output logic [31:0] pWdata,
  // APB completion
  input  logic [31:0] pReadData,
  input  logic        pReady,
  input  logic        pSlvErr
);

  // The timeout counter is 16 bits wide, so the limit must fit in it.
  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gBadTimeout
      $error("uart_apb_master: TIMEOUT_CYCLES must be in 1..65535");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } stateT;

  stateT state;

`ifdef UART_APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);
  // Counts ACCESS cycles that ended without pReady.
  logic [15:0] timeoutCnt;
`endif

  // Bridge FSM. Every output is a register, so the APB and response signals
  // change only on clock edges. pAddr/pWrite/pWdata double as the command
  // latch, which keeps them stable from SETUP until ACCESS ends.
  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      pSel      <= 1'b0;
      pEnable   <= 1'b0;
      pWrite    <= 1'b0;
      pAddr     <= '0;
      pWdata    <= '0;
`ifdef UART_APB_MASTER_TIMEOUT_EN
      timeoutCnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready comes out of reset low and rises at the first edge.
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            pSel      <= 1'b1;
            pEnable   <= 1'b0;
            pWrite    <= cmd_write;
            pAddr     <= cmd_addr;
            // Reads never put write data on the bus.
            pWdata    <= cmd_write ? cmd_wdata : 32'd0;
            state     <= SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          pEnable <= 1'b1;
          state   <= ACCESS;
`ifdef UART_APB_MASTER_TIMEOUT_EN
          timeoutCnt <= '0;
`endif
        end

        ACCESS: begin
          if (pReady) begin
            // pSlvErr is only meaningful in the cycle that completes the transfer.
            rsp_rdata <= pWrite ? 32'd0 : pReadData;
            rsp_err   <= pSlvErr;
            rsp_valid <= 1'b1;
            pSel      <= 1'b0;
            pEnable   <= 1'b0;
            pWrite    <= 1'b0;
            pAddr     <= '0;
            pWdata    <= '0;
            state     <= RESP;
          end
`ifdef UART_APB_MASTER_TIMEOUT_EN
          else if (timeoutCnt + 16'd1 == TimeoutLimit) begin
            // The slave never answered: give up and report an error.
            timeoutCnt <= timeoutCnt + 16'd1;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
            pSel       <= 1'b0;
            pEnable    <= 1'b0;
            pWrite     <= 1'b0;
            pAddr      <= '0;
            pWdata     <= '0;
            state      <= RESP;
          end else begin
            timeoutCnt <= timeoutCnt + 16'd1;
          end
`endif
        end

        RESP: begin
          // Hold the response until the host takes it.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_apb_master.md
UART_APB_MASTER -- requirements
Module: uart_apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of ACCESS-phase cycles without pReady before abort (range 1..65535).
REQ-002 SHALL have port pClk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port pReset, input, 1, the reset; it is asynchronous and active-high.
REQ-004 SHALL have port cmd_valid, input, 1, host command request.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted this cycle when high together with cmd_valid.
REQ-006 SHALL have port cmd_write, input, 1; 1 = write, 0 = read.
REQ-007 SHALL have ports cmd_addr and cmd_wdata, input, 32 each, the command address and write data.
REQ-008 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_rdata (output, 32) and rsp_err (output, 1), forming the response channel.
REQ-009 SHALL have ports pSel, pEnable and pWrite (output, 1 each) and pAddr and pWdata (output, 32 each), forming the APB request.
REQ-010 SHALL have ports pReadData (input, 32), pReady (input, 1) and pSlvErr (input, 1), forming the APB completion.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP.
REQ-012 IDLE: SHALL drive cmd_ready=1 and all APB controls at 0. On cmd_valid, SHALL latch cmd_write, cmd_addr and cmd_wdata and move to SETUP.
REQ-013 cmd_ready SHALL be 0 in SETUP, ACCESS and RESP; only one transfer is outstanding at a time.
REQ-014 SETUP, lasting exactly 1 cycle: SHALL drive pSel=1, pEnable=0, and pWrite/pAddr/pWdata from the latched values, then move to ACCESS.
REQ-015 ACCESS: SHALL drive pSel=1 and pEnable=1. pAddr, pWrite and pWdata SHALL stay stable from SETUP through the end of ACCESS.
REQ-016 ACCESS: on pReady=1, SHALL capture rsp_rdata = pReadData for reads or 0 for writes, and rsp_err = pSlvErr, then move to RESP.
REQ-017 While in ACCESS with pReady=0, SHALL remain in ACCESS (wait states).
REQ-018 RESP: SHALL drive rsp_valid=1 and pSel=pEnable=0. rsp_rdata and rsp_err SHALL be held until rsp_ready=1, then the FSM SHALL return to IDLE.
REQ-019 Minimum latency: command accepted at cycle N, SETUP at N+1, ACCESS at N+2 (pReady=1), rsp_valid at N+3.
REQ-020 If rsp_ready=1 in the first RESP cycle, the next command SHALL be acceptable 1 cycle later (IDLE).
REQ-021 pWdata SHALL be 0 during read transfers.
REQ-022 pSlvErr SHALL be sampled only in the ACCESS cycle where pReady=1 and ignored otherwise.
REQ-023 cmd_* changes after acceptance SHALL NOT affect the in-flight transfer.

Reset
REQ-024 While pReset=1, regardless of clock: state=IDLE, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, pSel=0, pEnable=0, pWrite=0, pAddr=0, pWdata=0, timeout counter=0.
REQ-025 After pReset deasserts, cmd_ready SHALL rise at the first pClk edge.
REQ-026 Reset during SETUP, ACCESS or RESP SHALL abort the transfer immediately. No response SHALL be issued for it.

Configuration
REQ-027 Macro UART_APB_MASTER_TIMEOUT_EN SHALL gate the ACCESS timeout feature.
REQ-028 With the macro defined: a 16-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pReady=0. When it reaches TIMEOUT_CYCLES, the FSM SHALL move to RESP with rsp_err=1 and rsp_rdata=0, and SHALL drop pSel/pEnable the next cycle.
REQ-029 With the macro undefined: no counter logic SHALL exist, and ACCESS SHALL wait indefinitely for pReady.

Verification
REQ-030 Write to 0x03 with data 0x0000_0001 and pReady tied 1 -> SETUP at cycle 1 (pSel=1, pEnable=0, pAddr=0x03, pWrite=1), ACCESS at cycle 2, rsp_valid at cycle 3 with rsp_rdata=0 and rsp_err=0.
REQ-031 Read of 0x05, slave returns pReadData=0x0000_0006 after 3 wait states -> pEnable high for 4 cycles, then rsp_rdata=0x6 and rsp_err=0.
REQ-032 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable for 5 cycles, cmd_ready=0 throughout, and a new cmd_valid is not accepted.
REQ-033 pReset=1 asserted mid-ACCESS -> pSel, pEnable and rsp_valid are 0 with no clock edge, and no response is produced after release.
REQ-034 With the macro defined, TIMEOUT_CYCLES=4 and pReady stuck 0 -> rsp_valid after 4 ACCESS cycles with rsp_err=1 and rsp_rdata=0. Without the macro, still waiting after 100 cycles.
REQ-035 Read returning pReady=1 with pSlvErr=1 -> rsp_err=1, rsp_rdata = the pReadData value, and the FSM returns to IDLE after rsp_ready.
